// File: rtl/sphere_update_scheduler_pkg.sv
// Shared types and constants for the sphere update scheduler.
// Descriptor layout: {x, y, z, r, colour}.
package sphere_update_scheduler_pkg;

    localparam int unsigned SPHERE_W = 64;

    typedef struct packed {
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic signed [15:0] z;
        logic [7:0]         r;
        logic [7:0]         colour;
    } sphere_t;

    localparam sphere_t SPHERE_RESET_S = '{
        x:      -16'sd100,
        y:      -16'sd200,
        z:      16'sd400,
        r:      8'd10,
        colour: 8'd0
    };

    localparam logic [SPHERE_W-1:0] SPHERE_RESET = SPHERE_RESET_S;

    typedef enum logic [1:0] {
        IDLE,
        COMMIT,
        HOLD
    } sched_state_t;

endpackage

// File: rtl/sphere_fifo.sv
// Synchronous descriptor FIFO; a pop of a full FIFO makes room for a push in the same cycle.
module sphere_fifo #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned SPHERE_W   = 64,
    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH),
    localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic                pop,
    input  logic [SPHERE_W-1:0] data_in,
    output logic [SPHERE_W-1:0] head_c,
    output logic [LVL_W-1:0]    level,
    output logic                full_c,
    output logic                empty_c
);

    logic [SPHERE_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic                do_push_c;
    logic                do_pop_c;

    assign full_c    = (level == LVL_W'(FIFO_DEPTH));
    assign empty_c   = (level == '0);
    assign do_pop_c  = pop && !empty_c;
    assign do_push_c = push && (!full_c || do_pop_c);
    assign head_c    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push_c, do_pop_c})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push_c) mem[wr_ptr] <= data_in;
    end

endmodule

// File: rtl/sphere_update_scheduler.sv
// Buffers SPI sphere descriptors and commits one per idle scanline window.
// Build option: SPHERE_FRAME_SYNC_EN restricts commits to windows with next_y == 0.
module sphere_update_scheduler #(
    parameter int unsigned FIFO_DEPTH             = 4,
    parameter int unsigned SPHERE_W               = sphere_update_scheduler_pkg::SPHERE_W,
    parameter logic [SPHERE_W-1:0] SPHERE_RESET   = sphere_update_scheduler_pkg::SPHERE_RESET
) (
    input  logic                               CLK100MHZ,
    input  logic                               ck_rst,
    input  logic                               recv_dv,
    input  logic [SPHERE_W-1:0]                recv_64bit,
    input  logic                               overflow_clr,
    input  logic                               next_line,
    input  logic [11:0]                        next_y,
    input  logic                               render_busy,
    output logic                               recv_ready,
    output logic                               overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
    output logic [SPHERE_W-1:0]                sphere,
    output logic                               update_pulse
);

    import sphere_update_scheduler_pkg::*;

    sched_state_t        state;
    sched_state_t        state_nxt;
    logic                pop_c;
    logic                window_c;
    logic                full_c;
    logic                empty_c;
    logic                drop_c;
    logic [SPHERE_W-1:0] head_c;

    sphere_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .SPHERE_W   (SPHERE_W)
    ) u_fifo (
        .clk     (CLK100MHZ),
        .rst     (ck_rst),
        .push    (recv_dv),
        .pop     (pop_c),
        .data_in (recv_64bit),
        .head_c  (head_c),
        .level   (fifo_level),
        .full_c  (full_c),
        .empty_c (empty_c)
    );

`ifdef SPHERE_FRAME_SYNC_EN
    assign window_c = !empty_c && !render_busy && !next_line && (next_y == 12'd0);
`else
    logic unused_next_y_c;
    assign unused_next_y_c = ^next_y;
    assign window_c = !empty_c && !render_busy && !next_line;
`endif

    // A push is lost only when full and no pop frees a slot this cycle.
    assign drop_c = recv_dv && full_c && !pop_c;

    always_ff @(posedge CLK100MHZ or posedge ck_rst) begin
        if (ck_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop_c     = 1'b0;
        case (state)
            IDLE: begin
                if (window_c) state_nxt = COMMIT;
            end
            COMMIT: begin
                pop_c     = 1'b1;
                state_nxt = HOLD;
            end
            HOLD: begin
                if (next_line) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ or posedge ck_rst) begin
        if (ck_rst) begin
            sphere       <= SPHERE_RESET;
            update_pulse <= 1'b0;
            recv_ready   <= 1'b1;
            overflow     <= 1'b0;
        end else begin
            if (pop_c) sphere <= head_c;
            update_pulse <= pop_c;
            recv_ready   <= !full_c;
            if (drop_c)            overflow <= 1'b1;
            else if (overflow_clr) overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sphere_update_scheduler.sv
// Directed bench for sphere_update_scheduler (default build; SPHERE_FRAME_SYNC_EN variant at the end).
module tb_sphere_update_scheduler;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned SPHERE_W   = 64;
    localparam int unsigned LVL_W      = 3;
    localparam logic [63:0] EXP_RESET  = 64'hFF9C_FF38_0190_0A00;

    logic                CLK100MHZ;
    logic                ck_rst;
    logic                recv_dv;
    logic [SPHERE_W-1:0] recv_64bit;
    logic                overflow_clr;
    logic                next_line;
    logic [11:0]         next_y;
    logic                render_busy;
    logic                recv_ready;
    logic                overflow;
    logic [LVL_W-1:0]    fifo_level;
    logic [SPHERE_W-1:0] sphere;
    logic                update_pulse;

    int tests  = 0;
    int failed = 0;
    int pulses = 0;

    logic [63:0] ow [6];

    sphere_update_scheduler #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .CLK100MHZ    (CLK100MHZ),
        .ck_rst       (ck_rst),
        .recv_dv      (recv_dv),
        .recv_64bit   (recv_64bit),
        .overflow_clr (overflow_clr),
        .next_line    (next_line),
        .next_y       (next_y),
        .render_busy  (render_busy),
        .recv_ready   (recv_ready),
        .overflow     (overflow),
        .fifo_level   (fifo_level),
        .sphere       (sphere),
        .update_pulse (update_pulse)
    );

    initial CLK100MHZ = 1'b0;
    always #5 CLK100MHZ = ~CLK100MHZ;

    task automatic tick;
        @(posedge CLK100MHZ);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            if (update_pulse) pulses++;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [63:0] w);
        recv_dv    = 1'b1;
        recv_64bit = w;
        run(1);
        recv_dv    = 1'b0;
    endtask

    task automatic line_window;
        next_line = 1'b1;
        run(1);
        next_line = 1'b0;
    endtask

    initial begin
        ow[0] = 64'h1111_0000_0000_0001;
        ow[1] = 64'h2222_0000_0000_0002;
        ow[2] = 64'h3333_0000_0000_0003;
        ow[3] = 64'h4444_0000_0000_0004;
        ow[4] = 64'h5555_0000_0000_0005;
        ow[5] = 64'h6666_0000_0000_0006;

        ck_rst       = 1'b1;
        recv_dv      = 1'b0;
        recv_64bit   = '0;
        overflow_clr = 1'b0;
        next_line    = 1'b0;
        render_busy  = 1'b0;
`ifdef SPHERE_FRAME_SYNC_EN
        next_y       = 12'd0;
`else
        next_y       = 12'd37;
`endif

        // Reset values
        #12;
        check("rst_sphere",   sphere,       EXP_RESET);
        check("rst_level",    64'(fifo_level), 64'd0);
        check("rst_ready",    64'(recv_ready), 64'd1);
        check("rst_overflow", 64'(overflow),   64'd0);
        check("rst_pulse",    64'(update_pulse), 64'd0);
        tick();
        ck_rst = 1'b0;
        tick();

        // Single update: pulse 2 edges after the push edge
        recv_dv    = 1'b1;
        recv_64bit = 64'h0000_1234_5678_9ABC;
        tick();
        recv_dv = 1'b0;
        check("single_lvl_after_push", 64'(fifo_level), 64'd1);
        check("single_no_pulse_e0",    64'(update_pulse), 64'd0);
        tick();
        check("single_no_pulse_e1",    64'(update_pulse), 64'd0);
        tick();
        check("single_pulse_e2",       64'(update_pulse), 64'd1);
        check("single_sphere",         sphere, 64'h0000_1234_5678_9ABC);
        check("single_lvl_drained",    64'(fifo_level), 64'd0);
        tick();
        check("single_pulse_one_cycle", 64'(update_pulse), 64'd0);
        line_window();

        // Busy gating
        render_busy = 1'b1;
        pulses = 0;
        push(64'hABCD_0000_0000_00EF);
        run(50);
        check("busy_no_pulse", 64'(pulses), 64'd0);
        check("busy_level",    64'(fifo_level), 64'd1);
        render_busy = 1'b0;
        tick();
        check("busy_drop_e1_no_pulse", 64'(update_pulse), 64'd0);
        tick();
        check("busy_drop_e2_pulse", 64'(update_pulse), 64'd1);
        check("busy_sphere",        sphere, 64'hABCD_0000_0000_00EF);
        line_window();

        // One commit per line window
        pulses = 0;
        push(ow[0]);
        push(ow[1]);
        push(ow[2]);
        run(5);
        check("line_one_commit", 64'(pulses), 64'd1);
        check("line_level2",     64'(fifo_level), 64'd2);
        check("line_sphere0",    sphere, ow[0]);
        line_window();
        run(3);
        check("line_second_commit", 64'(pulses), 64'd2);
        check("line_sphere1",       sphere, ow[1]);
        check("line_level1",        64'(fifo_level), 64'd1);
        line_window();
        run(3);
        check("line_sphere2", sphere, ow[2]);
        check("line_level0",  64'(fifo_level), 64'd0);

        // Overflow: four fill, fifth dropped while clear is asserted (set wins)
        render_busy = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) push(ow[i]);
        check("ovf_not_yet", 64'(overflow), 64'd0);
        overflow_clr = 1'b1;
        push(ow[4]);
        overflow_clr = 1'b0;
        check("ovf_set_wins", 64'(overflow),   64'd1);
        check("ovf_level4",   64'(fifo_level), 64'd4);
        check("ovf_ready0",   64'(recv_ready), 64'd0);
        overflow_clr = 1'b1;
        run(1);
        overflow_clr = 1'b0;
        check("ovf_cleared",  64'(overflow), 64'd0);
        check("ovf_no_pulse", 64'(pulses),   64'd0);

        // Drain; first commit coincides with a push into the full FIFO
        render_busy = 1'b0;
        line_window();
        run(1);
        recv_dv    = 1'b1;
        recv_64bit = ow[5];
        run(1);
        recv_dv = 1'b0;
        check("pp_level_unchanged", 64'(fifo_level), 64'd4);
        check("pp_sphere",          sphere, ow[0]);
        check("pp_pulse",           64'(update_pulse), 64'd1);
        check("pp_no_overflow",     64'(overflow), 64'd0);
        line_window(); run(3);
        check("drain_w1", sphere, ow[1]);
        check("drain_l3", 64'(fifo_level), 64'd3);
        line_window(); run(3);
        check("drain_w2", sphere, ow[2]);
        line_window(); run(3);
        check("drain_w3", sphere, ow[3]);
        line_window(); run(3);
        check("drain_w5", sphere, ow[5]);
        check("drain_l0", 64'(fifo_level), 64'd0);
        check("drain_ready", 64'(recv_ready), 64'd1);

        // Asynchronous reset mid-cycle discards buffered words
        render_busy = 1'b1;
        for (int i = 0; i < 5; i++) push(ow[i]);
        check("prerst_overflow", 64'(overflow), 64'd1);
        #3;
        ck_rst = 1'b1;
        #1;
        check("arst_sphere",   sphere, EXP_RESET);
        check("arst_level",    64'(fifo_level), 64'd0);
        check("arst_ready",    64'(recv_ready), 64'd1);
        check("arst_overflow", 64'(overflow),   64'd0);
        tick();
        ck_rst = 1'b0;

        // Open window with an empty FIFO: nothing commits
        render_busy = 1'b0;
        pulses = 0;
        run(6);
        check("empty_no_pulse", 64'(pulses), 64'd0);
        check("empty_sphere",   sphere, EXP_RESET);

`ifdef SPHERE_FRAME_SYNC_EN
        next_y = 12'd37;
        pulses = 0;
        push(64'h0000_1234_5678_9ABC);
        run(10);
        check("fs_no_commit_y37", 64'(pulses), 64'd0);
        check("fs_level1",        64'(fifo_level), 64'd1);
        next_y = 12'd0;
        run(3);
        check("fs_commit_y0", 64'(pulses), 64'd1);
        check("fs_sphere",    sphere, 64'h0000_1234_5678_9ABC);
`else
        next_y = 12'd37;
        pulses = 0;
        push(64'h0000_1234_5678_9ABC);
        run(3);
        check("ny_ignored_commit", 64'(pulses), 64'd1);
        check("ny_ignored_sphere", sphere, 64'h0000_1234_5678_9ABC);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/sphere_update_scheduler.md
Name: sphere_update_scheduler

Overview:
Sits between the SPI receiver and the raytracing controller. Buffers incoming 64-bit sphere descriptors in a small FIFO. Commits at most one descriptor to the active sphere register, and only in a window where no worker is rendering, so a scanline is never traced against a half-changed scene. Drives the "ready for more" flag back to the MCU.

Parameters:
FIFO_DEPTH, 4, number of buffered descriptors (power of two, >= 2)
SPHERE_W, 64, descriptor width in bits (matches Types::Sphere)
SPHERE_RESET, Types::SPHERE_RESET, active sphere value after reset (x=-100, y=-200, z=400, r=10, colour=0)

Ports:
CLK100MHZ  in   1  system clock
ck_rst  in   1  reset; one clock; reset is asynchronous and active-high
recv_dv  in   1  one-cycle strobe, recv_64bit valid
recv_64bit  in   SPHERE_W  descriptor from SPI
overflow_clr  in   1  clears the sticky overflow flag
next_line  in   1  VGA line request, level; high while the controller must idle
next_y  in   12  VGA line index (0..479) of the requested line
render_busy  in   1  high while any worker is busy or the controller is outside READY
recv_ready  out  1  registered; high when the FIFO is not full
overflow  out  1  sticky; a push arrived while the FIFO was full
fifo_level  out  $clog2(FIFO_DEPTH+1)  number of stored descriptors
sphere  out  SPHERE_W  active sphere, fed to the workers
update_pulse  out  1  one-cycle strobe in the cycle sphere takes a new value

Behaviour:
- Reset values:
  - sphere=SPHERE_RESET, fifo_level=0, recv_ready=1, overflow=0, update_pulse=0.
  - FSM enters IDLE; FIFO pointers are 0.
  - Reset mid-operation discards all buffered words.
- Push:
  - Occurs when recv_dv=1 and the FIFO is not full; the word is stored at the write pointer.
  - fifo_level reflects the push on the next edge.
- Push while full:
  - The word is dropped and overflow is set.
  - overflow is cleared only by overflow_clr or reset; set wins if both occur in the same cycle.
- recv_ready is registered (one-cycle lag) and equals !full of the previous cycle. The MCU must not rely on it for back-to-back pushes.
- Pointers wrap modulo FIFO_DEPTH. Full/empty are derived from fifo_level.
- FSM states:
  - IDLE:
    - Commit condition: FIFO non-empty, render_busy=0, next_line=0.
    - When the condition holds, go to COMMIT.
  - COMMIT, one cycle:
    - Pop the head; sphere <= head; update_pulse=1.
    - Go to HOLD.
  - HOLD:
    - Wait for next_line=1, which marks the start of a new line request.
    - Then go to IDLE, so at most one commit happens per scanline window.
- Simultaneous push and pop in COMMIT: both take effect; fifo_level is unchanged; a pop of a full FIFO frees room for the push in the same cycle.
- Latency:
  - Word to sphere takes at least 2 cycles: push edge, IDLE evaluation, then COMMIT edge.
  - sphere and update_pulse change on the same edge.
- If render_busy rises while in IDLE, no commit occurs. If it rises during COMMIT, the commit still completes because it was qualified one cycle earlier.
- Empty FIFO with a window open: the FSM stays in IDLE and sphere holds its value.

Optional Feature:
Macro SPHERE_FRAME_SYNC_EN.
- Defined: the IDLE commit condition additionally requires next_y==12'd0. Updates therefore land only at frame start, and at most one descriptor is applied per frame (no tearing).
- Undefined: per-line commits as described above; next_y is unused.

Decomposition:
- Package Types: SPHERE_W, SPHERE_RESET constant, sched_state_t enum {IDLE, COMMIT, HOLD}.
- Sub-module sphere_fifo: synchronous FIFO with push/pop/level/full/empty, parameterised by FIFO_DEPTH and SPHERE_W, async active-high reset.
- sphere_update_scheduler holds the FSM, the active register, and the overflow/ready logic.

Test Plan:
- Reset check: assert ck_rst asynchronously mid-cycle -> sphere=SPHERE_RESET, fifo_level=0, recv_ready=1, overflow=0 before the next edge.
- Single update: push 64'h0000_1234_5678_9ABC with render_busy=0 and next_line=0 -> update_pulse high exactly 2 cycles after the push edge, sphere=0x123456789ABC, fifo_level back to 0.
- Busy gating: push a word with render_busy=1 held for 50 cycles -> no update_pulse and fifo_level=1; drop render_busy -> commit 2 cycles later.
- One commit per line: push 3 words with next_line kept 0 -> exactly one commit and fifo_level=2; pulse next_line 1 then 0 -> second commit.
- Overflow: push 5 words back-to-back with render_busy=1 -> fifo_level=4, overflow=1, recv_ready=0, first 4 words retained; overflow_clr -> overflow=0.
- SPHERE_FRAME_SYNC_EN defined: queued word, windows at next_y=37 -> no commit; window at next_y=0 -> commit.
